ssd_scan_ctrl: RTL and testbench

//   Time-multiplexed scan controller for an NDIG-digit common-anode seven-segment display.

---
 rtl/ssd_pkg.sv | 20 ++
 rtl/ssd_decoder.sv | 28 ++
 rtl/ssd_scan_ctrl.sv | 131 +++++++++++++
 tb/tb_ssd_scan_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared constants, scan state encoding and width helper for the seven-segment scan controller.
// Latency: none (declarations only).
// Backpressure: not applicable.
package ssd_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic       AN_OFF    = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } scan_state_t;

    // Counter width that never collapses to zero bits for tiny parameters.
    function automatic int clog2w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ssd_decoder.sv
// BCD nibble to active-low {a..g,dp} segment pattern; non-decimal nibbles go dark, dp is left off.
// Latency: combinational.
// Backpressure: none.
module ssd_decoder
    import ssd_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = 8'h03;
            4'd1:    seg = 8'h9F;
            4'd2:    seg = 8'h25;
            4'd3:    seg = 8'h0D;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h49;
            4'd6:    seg = 8'h41;
            4'd7:    seg = 8'h1F;
            4'd8:    seg = 8'h01;
            4'd9:    seg = 8'h09;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Multiplexed scan of an NDIG-digit common-anode display from a frame-synchronised shadow value.
// Latency: pins lag the scan decision by one clock; loads land at the next frame boundary (next cycle when disabled).
// Backpressure: none; a newer load simply overwrites the staged value and still earns one ack.
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int NDIG  = 4,
    parameter int DIV   = 50000,
    parameter int BLANK = 500
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              load,
    input  logic [4*NDIG-1:0] value_in,
    input  logic [NDIG-1:0]   dp_in,
    input  logic              lz_suppress,
    output logic              load_ack,
    output logic              frame_tick,
    output logic [NDIG-1:0]   an,
    output logic [7:0]        seg
);

    localparam int              CW         = clog2w(DIV);
    localparam int              IW         = clog2w(NDIG);
    localparam logic [CW-1:0]   CNT_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0]   CNT_BLANK  = CW'(BLANK);
    localparam logic [IW-1:0]   IDX_LAST   = IW'(NDIG - 1);
    localparam logic [NDIG-1:0] AN_ALL_OFF = {NDIG{AN_OFF}};
    localparam logic [NDIG-1:0] AN_ONE     = NDIG'(1);

    scan_state_t       state;
    logic [IW-1:0]     idx;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_nxt;
    logic [4*NDIG-1:0] shadow;
    logic [4*NDIG-1:0] staging;
    logic              pending;
    logic              frame_end;
    logic              apply;
    logic [3:0]        nib;
    logic [7:0]        dec;
    logic [NDIG-1:0]   zero_above;
    logic              lz_hit;
    logic [7:0]        seg_nxt;

    assign cnt_nxt   = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    assign frame_end = (state != ST_IDLE) && en && (cnt == CNT_LAST) && (idx == IDX_LAST);
    // A disabled display has no frame to tear, so staged data is taken immediately.
    assign apply     = pending && (frame_end || !en);

    assign nib = shadow[{idx, 2'b00} +: 4];

    ssd_decoder u_dec (
        .bcd (nib),
        .seg (dec)
    );

    // zero_above[k]: nibble k and every more significant nibble are zero.
    always_comb begin
        logic acc;
        acc        = 1'b1;
        zero_above = '0;
        for (int k = NDIG - 1; k >= 0; k--) begin
            acc           = acc && (shadow[4*k +: 4] == 4'd0);
            zero_above[k] = acc;
        end
    end

    assign lz_hit  = lz_suppress && (idx != '0) && zero_above[idx];
    assign seg_nxt = {dec[7:1] | {7{lz_hit}}, dec[0] & ~dp_in[idx]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            cnt        <= '0;
            shadow     <= '0;
            staging    <= '0;
            pending    <= 1'b0;
            load_ack   <= 1'b0;
            frame_tick <= 1'b0;
            an         <= AN_ALL_OFF;
            seg        <= SEG_BLANK;
        end else begin
            if (state == ST_DRIVE) begin
                an  <= ~(AN_ONE << idx);
                seg <= seg_nxt;
            end else begin
                an  <= AN_ALL_OFF;
                seg <= SEG_BLANK;
            end

            load_ack   <= apply;
            frame_tick <= frame_end;

            case (state)
                ST_IDLE: begin
                    idx <= '0;
                    cnt <= '0;
                    if (en) begin
                        state <= (BLANK == 0) ? ST_DRIVE : ST_BLANK;
                    end
                end
                default: begin
                    if (!en) begin
                        state <= ST_IDLE;
                        idx   <= '0;
                        cnt   <= '0;
                    end else begin
                        cnt   <= cnt_nxt;
                        state <= (cnt_nxt < CNT_BLANK) ? ST_BLANK : ST_DRIVE;
                        if (cnt == CNT_LAST) begin
                            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                        end
                    end
                end
            endcase

            if (apply) begin
                shadow <= staging;
            end
            // A load coinciding with apply refills staging and stays pending for the next boundary.
            if (load) begin
                staging <= value_in;
            end
            pending <= load || (pending && !apply);
        end
    end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Scoreboard bench for ssd_scan_ctrl: a time-indexed display model predicts pins, ack and tick per clock.
// Latency: expectations are pushed each cycle and popped one edge later by an independent monitor.
// Backpressure: none.
module tb_ssd_scan_ctrl;

    localparam int NDIG  = 4;
    localparam int DIV   = 8;
    localparam int BLANK = 2;

    logic        clk         = 1'b0;
    logic        rst_n       = 1'b1;
    logic        en          = 1'b0;
    logic        load        = 1'b0;
    logic [15:0] value_in    = 16'h0;
    logic [3:0]  dp_in       = 4'h0;
    logic        lz_suppress = 1'b0;
    logic        load_ack;
    logic        frame_tick;
    logic [3:0]  an;
    logic [7:0]  seg;

    ssd_scan_ctrl #(
        .NDIG  (NDIG),
        .DIV   (DIV),
        .BLANK (BLANK)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .load        (load),
        .value_in    (value_in),
        .dp_in       (dp_in),
        .lz_suppress (lz_suppress),
        .load_ack    (load_ack),
        .frame_tick  (frame_tick),
        .an          (an),
        .seg         (seg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic [7:0] seg;
        logic       ack;
        logic       tick;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_on   = 1'b0;

    // Behavioural display state: m_t counts clocks since the scan (re)started at digit 0.
    bit          m_run;
    int          m_t;
    logic [15:0] m_shadow;
    logic [15:0] m_staging;
    bit          m_pend;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
        end
    endtask

    // Lit segments in a..g order (a is the MSB), active-high.
    function automatic logic [6:0] lit_of(input int d);
        case (d)
            0:       return 7'b1111110;
            1:       return 7'b0110000;
            2:       return 7'b1101101;
            3:       return 7'b1111001;
            4:       return 7'b0110011;
            5:       return 7'b1011011;
            6:       return 7'b1011111;
            7:       return 7'b1110000;
            8:       return 7'b1111111;
            9:       return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [7:0] ref_seg(input logic [15:0] v, input int k,
                                           input logic [3:0] dp, input logic lz);
        int         d;
        logic [6:0] lit;
        d   = int'((v >> (4*k)) & 16'hF);
        lit = lit_of(d);
        if (lz && k > 0 && (v >> (4*k)) == 16'h0) lit = 7'b0;
        return {~lit, ~dp[k]};
    endfunction

    function automatic bit at_boundary();
        return m_run && (m_t % DIV == DIV - 1) && ((m_t / DIV) % NDIG == NDIG - 1);
    endfunction

    task automatic model_reset();
        m_run     = 1'b0;
        m_t       = 0;
        m_shadow  = 16'h0;
        m_staging = 16'h0;
        m_pend    = 1'b0;
    endtask

    task automatic model_cycle();
        exp_t       x;
        int         pos;
        int         slot;
        bit         boundary;
        bit         apply;
        logic [3:0] one;
        one    = 4'b0001;
        pos    = m_t % DIV;
        slot   = (m_t / DIV) % NDIG;
        x.an   = 4'hF;
        x.seg  = 8'hFF;
        if (m_run && pos >= BLANK) begin
            x.an  = ~(one << slot);
            x.seg = ref_seg(m_shadow, slot, dp_in, lz_suppress);
        end
        boundary = m_run && en && (pos == DIV - 1) && (slot == NDIG - 1);
        apply    = m_pend && (boundary || !en);
        x.tick   = boundary;
        x.ack    = apply;
        exp_q.push_back(x);
        if (apply) m_shadow = m_staging;
        if (load) m_staging = value_in;
        m_pend = load || (m_pend && !apply);
        if (en) begin
            m_t   = m_run ? m_t + 1 : 0;
            m_run = 1'b1;
        end else begin
            m_run = 1'b0;
            m_t   = 0;
        end
    endtask

    // Called at a negedge: drive inputs for this cycle, predict, then move to the next negedge.
    task automatic step(input bit e, input bit ld, input logic [15:0] v);
        en   = e;
        load = ld;
        value_in = ld ? v : 16'($urandom);
        model_cycle();
        @(negedge clk);
    endtask

    task automatic run(input int n, input bit e);
        repeat (n) step(e, 1'b0, 16'h0);
    endtask

    function automatic logic [15:0] rand_val();
        logic [15:0] v;
        for (int k = 0; k < 4; k++) v[4*k +: 4] = 4'($urandom_range(0, 11));
        return v >> (4 * $urandom_range(0, 3));
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_on && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("an", an, e.an);
                check("seg", seg, e.seg);
                check("load_ack", load_ack, e.ack);
                check("frame_tick", frame_tick, e.tick);
            end
        end
    end

    initial begin
        int  i;
        bit  en_r;
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        check("reset_an", an, 4'hF);
        check("reset_seg", seg, 8'hFF);
        check("reset_ack", load_ack, 1'b0);
        check("reset_tick", frame_tick, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        mon_on = 1'b1;

        // Basic value, ack at first boundary, then steady frames.
        step(1'b1, 1'b1, 16'h1234);
        run(3 * 32, 1'b1);

        // Two loads within one frame: latest wins, one ack.
        step(1'b1, 1'b1, 16'h1111);
        run(5, 1'b1);
        step(1'b1, 1'b1, 16'h2222);
        run(2 * 32 + 10, 1'b1);

        lz_suppress = 1'b1;
        step(1'b1, 1'b1, 16'h0070);
        run(64, 1'b1);

        lz_suppress = 1'b0;
        dp_in = 4'b0001;
        step(1'b1, 1'b1, 16'h000A);
        run(64, 1'b1);

        // Load on the boundary cycle is deferred a full frame.
        dp_in = 4'b0000;
        i = 0;
        while (!at_boundary() && i < 64) begin
            step(1'b1, 1'b0, 16'h0);
            i++;
        end
        step(1'b1, 1'b1, 16'h9876);
        run(70, 1'b1);

        // Disable mid digit 2, load while idle, re-enable.
        i = 0;
        while (!(m_run && (m_t / DIV) % NDIG == 2 && m_t % DIV == 4) && i < 64) begin
            step(1'b1, 1'b0, 16'h0);
            i++;
        end
        run(3, 1'b0);
        step(1'b0, 1'b1, 16'h5555);
        run(4, 1'b0);
        run(40, 1'b1);

        en_r = 1'b1;
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 99) < 2) en_r = !en_r;
            if ($urandom_range(0, 15) == 0) lz_suppress = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) dp_in = 4'($urandom);
            step(en_r, $urandom_range(0, 19) == 0, rand_val());
        end

        // Reset while a digit is lit and a load is pending: pins go dark without a clock.
        lz_suppress = 1'b0;
        dp_in = 4'b0000;
        run(40, 1'b1);
        step(1'b1, 1'b1, 16'h4321);
        i = 0;
        while (!(m_run && m_t % DIV >= BLANK + 1) && i < 64) begin
            step(1'b1, 1'b0, 16'h0);
            i++;
        end
        mon_on = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrun_reset_an", an, 4'hF);
        check("midrun_reset_seg", seg, 8'hFF);
        exp_q.delete();
        repeat (2) @(negedge clk);
        check("held_reset_ack", load_ack, 1'b0);
        check("held_reset_tick", frame_tick, 1'b0);
        rst_n = 1'b1;
        model_reset();
        mon_on = 1'b1;
        run(80, 1'b1);
        run(5, 1'b0);

        @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 0);
        check("enough_checks", n_checks > 1000, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
